// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, register zero and load type codes.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_e;

endpackage

// File: rtl/load_aligner.sv
// Combinational sub-word load extraction and extension; shared with the MEM-stage forwarding path.
module load_aligner #(
    parameter int W = 32
) (
    input  logic [2:0]   load_type,
    input  logic [1:0]   byte_off,
    input  logic [W-1:0] mem_data,
    output logic [W-1:0] data
);
    import mips_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data[7:0];
        case (byte_off)
            2'd1:    byte_sel = mem_data[15:8];
            2'd2:    byte_sel = mem_data[23:16];
            2'd3:    byte_sel = mem_data[31:24];
            default: byte_sel = mem_data[7:0];
        endcase
        // Halfword accesses are assumed aligned, so only the upper offset bit matters.
        half_sel = byte_off[1] ? mem_data[31:16] : mem_data[15:0];

        case (load_type)
            LT_LB:   data = {{(W-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  data = {{(W-8){1'b0}}, byte_sel};
            LT_LH:   data = {{(W-16){half_sel[15]}}, half_sel};
            LT_LHU:  data = {{(W-16){1'b0}}, half_sel};
            default: data = mem_data;
        endcase
    end

endmodule

// File: rtl/wb_regfile_writer.sv
// MIPS write-back stage: MEM/WB latch, result select, register file write port and forwarding tap.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_regfile_writer #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_byte_off,
    input  logic [ADDR_W-1:0] in_w_addr,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retire_count
);
    import mips_pkg::*;

    // Handshake: no ready path. in_valid marks a real instruction; stall holds the
    // latch (the write is re-presented), flush replaces the incoming one with a bubble
    // and wins over stall. The latch empties into the register file every unstalled edge.
    logic              valid_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [2:0]        load_type_q;
    logic [1:0]        byte_off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] load_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            load_type_q  <= '0;
            byte_off_q   <= '0;
            addr_q       <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
        end else if (!stall) begin
            valid_q      <= in_valid;
            reg_write_q  <= in_reg_write;
            mem_to_reg_q <= in_mem_to_reg;
            load_type_q  <= in_load_type;
            byte_off_q   <= in_byte_off;
            addr_q       <= in_w_addr;
            alu_result_q <= in_alu_result;
            mem_data_q   <= in_mem_data;
        end
    end

    load_aligner #(.W(DATA_W)) u_load_aligner (
        .load_type (load_type_q),
        .byte_off  (byte_off_q),
        .mem_data  (mem_data_q),
        .data      (load_data)
    );

    assign wr_en     = valid_q & reg_write_q & (addr_q != ADDR_W'(REG_ZERO));
    assign w_addr    = addr_q;
    assign w_data    = mem_to_reg_q ? load_data : alu_result_q;
    assign fwd_valid = wr_en;
    assign fwd_addr  = w_addr;
    assign fwd_data  = w_data;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_q;

    // An instruction retires when the latch gives it up, including when flush bubbles the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (valid_q && (flush || !stall)) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Self-checking bench for wb_regfile_writer: reference latch model feeding an expected queue.
module tb_wb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [2:0]  in_load_type;
    logic [1:0]  in_byte_off;
    logic [4:0]  in_w_addr;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic        wr_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    // Expected write port packed as {wr_en, w_addr, w_data}
    logic [37:0] exp_q[$];

    // Reference model state
    logic        m_valid, m_rw, m_m2r;
    logic [2:0]  m_lt;
    logic [1:0]  m_off;
    logic [4:0]  m_addr;
    logic [31:0] m_alu, m_mem;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile_writer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_mem_to_reg (in_mem_to_reg),
        .in_load_type  (in_load_type),
        .in_byte_off   (in_byte_off),
        .in_w_addr     (in_w_addr),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .wr_en         (wr_en),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .retire_count  (retire_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_align(input logic [2:0] lt, input logic [1:0] off,
                                              input logic [31:0] mem);
        logic [31:0] b;
        logic [31:0] h;
        b = (mem >> (8 * int'(off))) & 32'h0000_00FF;
        h = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        case (lt)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [1:0] off, input logic [4:0] a,
                         input logic [31:0] alu, input logic [31:0] mem);
        rst = r; stall = s; flush = f; in_valid = v; in_reg_write = rw;
        in_mem_to_reg = m2r; in_load_type = lt; in_byte_off = off;
        in_w_addr = a; in_alu_result = alu; in_mem_data = mem;
    endtask

    // One clock: advance the model on the edge, queue its prediction, then compare #1 later.
    task automatic cycle(input string tag);
        logic [37:0] e;
        logic        e_wr;
        @(posedge clk);
        if (rst) begin
            {m_valid, m_rw, m_m2r, m_lt, m_off, m_addr, m_alu, m_mem} = '0;
            m_cnt = '0;
        end else begin
            if (m_valid && (flush || !stall)) m_cnt = m_cnt + 32'd1;
            if (flush) begin
                {m_valid, m_rw, m_m2r, m_lt, m_off, m_addr, m_alu, m_mem} = '0;
            end else if (!stall) begin
                m_valid = in_valid; m_rw = in_reg_write; m_m2r = in_mem_to_reg;
                m_lt = in_load_type; m_off = in_byte_off; m_addr = in_w_addr;
                m_alu = in_alu_result; m_mem = in_mem_data;
            end
        end
        e_wr = m_valid && m_rw && (m_addr != 5'd0);
        exp_q.push_back({e_wr, m_addr, m_m2r ? ref_align(m_lt, m_off, m_mem) : m_alu});
        #1;
        e = exp_q.pop_front();
        check({tag, ".wr_en"},  64'(wr_en),  64'(e[37]));
        check({tag, ".w_addr"}, 64'(w_addr), 64'(e[36:32]));
        check({tag, ".w_data"}, 64'(w_data), 64'(e[31:0]));
        check({tag, ".fwd"}, 64'({fwd_valid, fwd_addr, fwd_data}), 64'(e));
`ifdef WB_RETIRE_COUNT_EN
        check({tag, ".retire"}, 64'(retire_count), 64'(m_cnt));
`else
        check({tag, ".retire"}, 64'(retire_count), 64'd0);
`endif
    endtask

    logic [31:0] load_exp[6];
    logic [2:0]  load_lt[6];
    logic [1:0]  load_off[6];

    initial begin
        load_lt  = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0};
        load_off = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
        load_exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                     32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

        // Reset with a live instruction on the inputs
        drive(1, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd5, 32'd25, 32'd0);
        cycle("reset");
        check("reset.zero", 64'({wr_en, w_addr, w_data}), 64'd0);
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd5, 32'd25, 32'd0);
        cycle("post_reset");
        check("post_reset.val", 64'({wr_en, w_addr, w_data}), 64'({1'b1, 5'd5, 32'd25}));

        // ALU write-back, then a write to $0
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd1, 32'd50, 32'd0);
        cycle("alu");
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'd100, 32'd0);
        cycle("reg0");
        check("reg0.suppress", 64'({wr_en, w_addr}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, 1, 1, load_lt[i], load_off[i], 5'd7, 32'hDEAD_BEEF, 32'h80FF_7F01);
            cycle("load");
            check($sformatf("load%0d.const", i), 64'(w_data), 64'(load_exp[i]));
        end

        // Stall holds the write for four cycles
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd3, 32'd200, 32'd0);
        cycle("stall_cap");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'(9 + i), 32'(300 + i), 32'd0);
            cycle("stall_hold");
            check("stall.const", 64'({wr_en, w_addr, w_data}), 64'({1'b1, 5'd3, 32'd200}));
        end
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd12, 32'd400, 32'd0);
        cycle("stall_rel");

        // Flush beats stall
        drive(0, 1, 1, 1, 1, 0, 3'd0, 2'd0, 5'd2, 32'd77, 32'd0);
        cycle("flush");
        check("flush.bubble", 64'({wr_en, fwd_valid}), 64'd0);

        // Retire counting: 4 valid (one store, one $0), a bubble, 2-cycle stall
        drive(1, 0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0);
        cycle("rc_rst");
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd4, 32'd1, 32'd0);
        cycle("rc_a");
        drive(0, 0, 0, 1, 0, 0, 3'd0, 2'd0, 5'd6, 32'd2, 32'd0);
        cycle("rc_store");
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'd3, 32'd0);
        cycle("rc_r0");
        drive(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd8, 32'd4, 32'd0);
        cycle("rc_d");
        drive(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0);
        cycle("rc_bubble");
        drive(0, 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd9, 32'd5, 32'd0);
        cycle("rc_stall");
        cycle("rc_stall");
`ifdef WB_RETIRE_COUNT_EN
        check("retire.total", 64'(retire_count), 64'd4);
`else
        check("retire.total", 64'(retire_count), 64'd0);
`endif

        // Random traffic including mid-stream reset, stall and flush
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 31)), $urandom, $urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile_writer.md
Name: wb_regfile_writer

Overview:
- Write-back stage of the 5-stage MIPS pipeline; the producing end of the register file write port (`wr_en` / `w_addr` / `w_data`) that instruction decode reads from.
- Holds the MEM/WB pipeline register and selects ALU result or load data.
- Sign/zero-extends and aligns sub-word loads.
- Drives the register file write port and a forwarding tap for the hazard unit.

Parameters:
- DATA_W, 32, datapath and register width.
- ADDR_W, 5, register index width (32 registers).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  replace incoming instruction with a bubble
- in_valid  in  1  MEM stage holds a real instruction
- in_reg_write  in  1  instruction writes a register
- in_mem_to_reg  in  1  1 = result from memory, 0 = from ALU
- in_load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
- in_byte_off  in  2  effective address [1:0]
- in_w_addr  in  ADDR_W  destination register
- in_alu_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  raw word read from data memory
- wr_en  out  1  register file write enable
- w_addr  out  ADDR_W  register file write address
- w_data  out  DATA_W  register file write data
- fwd_valid  out  1  equals `wr_en`; tap for the forwarding unit
- fwd_addr  out  ADDR_W  equals `w_addr`
- fwd_data  out  DATA_W  equals `w_data`
- retire_count  out  32  retired-instruction count (feature only; otherwise tied to 0)

Behaviour:

Reset:
- On a rising edge with `rst`=1, all latch fields clear: valid=0, reg_write=0, addr=0, data fields=0.
- Consequently `wr_en`=0, `w_addr`=0, `w_data`=0 and all `fwd_*` outputs are 0 from the cycle after that edge.
- Reset asserted mid-stream discards the held instruction; no write occurs.

Latch update priority per rising edge: `rst` > `flush` > `stall` > capture.
- flush: valid:=0; other fields are don't-care but cleared to 0.
- stall (no flush): all fields hold their values.
- capture: all `in_*` fields are latched.
- Simultaneous `stall` and `flush`: a bubble is inserted.

Latency:
- An instruction captured at edge N drives the write port during the whole cycle N→N+1.
- The register file commits it on its own edge.

Write enable:
- `wr_en` = valid & reg_write & (addr != 0).
- Writes to $0 are suppressed, and `w_addr` still shows 0.
- `wr_en` stays high across a stall: the same write is re-presented. This is idempotent.

Data select and load alignment:
- `w_data` = `mem_to_reg` ? `load_align(mem_data)` : `alu_result`.
- Bytes are little-endian: byte k = `mem_data[8k+7:8k]` with k = `byte_off`.
- Halfword h = `byte_off[1]` selects `mem_data[31:16]` or `[15:0]`; `byte_off[0]` is ignored.
- LB and LH sign-extend; LBU and LHU zero-extend; LW passes `mem_data` unchanged.
- Load types 101–111 are treated as LW.
- `byte_off` is ignored for LW.

Timing:
- Outputs are combinational from the latch only, with no input-to-output combinational path.

Optional Feature:
- Macro `WB_RETIRE_COUNT_EN`.
- Defined:
  - A 32-bit `retire_count` is reset to 0.
  - It increments by 1 on each non-stalled edge where the latch is being vacated and the latch holds valid=1, i.e. the instruction leaves WB.
  - Counted instructions include stores and branches (valid but no write) and writes to $0.
  - `flush` does not suppress counting of the instruction currently leaving WB.
  - The count wraps from 0xFFFFFFFF to 0.
- Undefined: `retire_count` is a constant 0 and no counter flops are synthesized.

Decomposition:
- Shared package (`mips_pkg`) holds:
  - the load type codes LT_LW=3'b000, LT_LB=3'b001, LT_LBU=3'b010, LT_LH=3'b011, LT_LHU=3'b100;
  - DATA_W and ADDR_W defaults;
  - REG_ZERO=5'd0.
- One sub-module: `load_aligner`. It is purely combinational (load_type, byte_off, mem_data → aligned data) and is reused by the MEM-stage forwarding path.

Test Plan:
1. Reset: drive `rst`=1 with `in_valid`=1, `in_reg_write`=1, `in_w_addr`=5, `in_alu_result`=25 → after the edge `wr_en`=0, `w_addr`=0, `w_data`=0. Release reset → next edge `wr_en`=1, `w_addr`=5, `w_data`=25.
2. ALU write-back then $0 suppression: addr 1 with `in_alu_result`=50 → one cycle later `wr_en`=1, `w_addr`=1, `w_data`=50. Next, addr 0 with data 100 → `wr_en`=0.
3. Loads with `in_mem_data`=0x80FF7F01 and `in_mem_to_reg`=1:
   - LB off=3 → 0xFFFFFF80
   - LBU off=3 → 0x00000080
   - LB off=1 → 0x0000007F
   - LH off=2 → 0xFFFF80FF
   - LHU off=0 → 0x00007F01
   - LW → 0x80FF7F01
4. Stall: capture addr 3 / data 200, then hold `stall`=1 for 3 cycles while the inputs change → `wr_en`=1, `w_addr`=3, `w_data`=200 for all 4 cycles. On release the new instruction appears.
5. Flush priority: `stall`=1 and `flush`=1 together with addr 2 held → next cycle `wr_en`=0 and `fwd_valid`=0.
6. With `WB_RETIRE_COUNT_EN` defined: issue 4 valid instructions (one store, one write to $0), one bubble and a 2-cycle stall → `retire_count`=4. With the macro undefined, `retire_count` stays 0.
